// File: rtl/countdown_timer_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_if
// Control/status bundle between the menu logic and the countdown timer.
//   start     : one-cycle pulse, load load_bcd and (re)start the countdown
//   load_bcd  : start value, two BCD digits {tens, ones}
//   pause     : level, freezes the countdown while high
//   cancel    : one-cycle pulse, abort the countdown silently
//   seconds   : {active, tens_bcd, ones_bcd} for the seven-segment driver
//   busy      : countdown running or paused
//   done      : one-cycle expiry pulse
// master = controller side, slave = timer side.
// -----------------------------------------------------------------------------
interface countdown_timer_if;
    logic       start;
    logic [7:0] load_bcd;
    logic       pause;
    logic       cancel;
    logic [8:0] seconds;
    logic       busy;
    logic       done;

    modport master (
        output start, load_bcd, pause, cancel,
        input  seconds, busy, done
    );

    modport slave (
        input  start, load_bcd, pause, cancel,
        output seconds, busy, done
    );
endinterface

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// One-second BCD countdown feeding the seven-segment display driver.
//   clk_out : block clock (divided system clock)
//   reset   : asynchronous, active-low reset
//   bus     : countdown_timer_if.slave (start/load_bcd/pause/cancel in,
//             seconds/busy/done out, all outputs registered)
// Parameters:
//   TICKS_PER_SEC : clk_out cycles per decrement (2 .. 2^20)
//   PRESC_W       : prescaler width, 2^PRESC_W >= TICKS_PER_SEC
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int TICKS_PER_SEC = 20000,
    parameter int PRESC_W       = 20
) (
    input  logic                clk_out,
    input  logic                reset,
    countdown_timer_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_EXPIRE = 2'd3
    } state_t;

    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    // Clamp a BCD digit so illegal nibbles never reach the display.
    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        if (d > 4'd9) begin
            sat_digit = 4'd9;
        end else begin
            sat_digit = d;
        end
    endfunction

    // Two-digit BCD decrement; borrow turns ones 0 into 9.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0) begin
            bcd_dec = {v[7:4], v[3:0] - 4'd1};
        end else begin
            bcd_dec = {v[7:4] - 4'd1, 4'd9};
        end
    endfunction

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         bcd_q,   bcd_d;
    logic               active_q, active_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic               tick_s;
    logic [7:0]         load_s;

    assign tick_s = (presc_q == TICK_LAST);
    assign load_s = {sat_digit(bus.load_bcd[7:4]), sat_digit(bus.load_bcd[3:0])};

    // Next-state, prescaler and value logic; priority cancel > start > pause.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        bcd_d    = bcd_q;
        active_d = active_q;

        if (bus.cancel) begin
            state_d  = ST_IDLE;
            presc_d  = '0;
            bcd_d    = 8'h00;
            active_d = 1'b0;
        end else if (bus.start) begin
            presc_d  = '0;
            active_d = 1'b1;
            if (load_s != 8'h00) begin
                state_d = ST_RUN;
                bcd_d   = load_s;
            end else begin
                state_d = ST_EXPIRE;
                bcd_d   = 8'h00;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (tick_s) begin
                        // A tick always lands, even with pause raised.
                        presc_d = '0;
                        if (bcd_q == 8'h01) begin
                            state_d = ST_EXPIRE;
                            bcd_d   = 8'h00;
                        end else begin
                            bcd_d   = bcd_dec(bcd_q);
                            state_d = bus.pause ? ST_PAUSE : ST_RUN;
                        end
                    end else if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                end
                ST_PAUSE: begin
                    // Every cycle with pause low advances the prescaler; a
                    // paused count is never at TICK_LAST since that cycle ticks.
                    if (!bus.pause) begin
                        state_d = ST_RUN;
                        presc_d = presc_q + PRESC_ONE;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_EXPIRE: begin
                    state_d  = ST_IDLE;
                    presc_d  = '0;
                    bcd_d    = 8'h00;
                    active_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    presc_d  = '0;
                    bcd_d    = 8'h00;
                    active_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        done_d = (state_d == ST_EXPIRE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            bcd_q    <= 8'h00;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            bcd_q    <= bcd_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.seconds = {active_q, bcd_q};
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Table-driven vectors, hand-written corner sequences and randomized stimulus
// checked against a decimal reference model of the countdown timer.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int T = 4;

    logic clk_out;
    logic reset;

    countdown_timer_if bus_if ();

    countdown_timer #(
        .TICKS_PER_SEC (T),
        .PRESC_W       (3)
    ) dut (
        .clk_out (clk_out),
        .reset   (reset),
        .bus     (bus_if)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model (decimal value, tick counter) ---------
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;
    int m_mode = M_IDLE;
    int m_val  = 0;
    int m_cnt  = 0;

    function automatic int sanitize(input logic [7:0] ld);
        int t;
        int o;
        t = (ld[7:4] > 4'd9) ? 9 : int'(ld[7:4]);
        o = (ld[3:0] > 4'd9) ? 9 : int'(ld[3:0]);
        return t * 10 + o;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_val  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic st, input logic [7:0] ld,
                              input logic pa, input logic ca);
        int v;
        v = sanitize(ld);
        if (ca) begin
            model_reset();
        end else if (st) begin
            m_cnt  = 0;
            m_val  = v;
            m_mode = (v > 0) ? M_RUN : M_EXPIRED;
        end else begin
            case (m_mode)
                M_RUN: begin
                    if (m_cnt == T - 1) begin
                        m_cnt = 0;
                        m_val = m_val - 1;
                        if (m_val == 0)  m_mode = M_EXPIRED;
                        else if (pa)     m_mode = M_PAUSED;
                    end else if (pa) begin
                        m_mode = M_PAUSED;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
                M_PAUSED: begin
                    if (!pa) begin
                        m_mode = M_RUN;
                        m_cnt  = m_cnt + 1;
                    end
                end
                M_EXPIRED: model_reset();
                default: ;
            endcase
        end
    endtask

    function automatic logic [8:0] m_seconds();
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(m_val / 10);
        o = 4'(m_val % 10);
        if (m_mode == M_IDLE) return 9'h000;
        return {1'b1, t, o};
    endfunction

    // ---------------- check helpers -----------------------------------------
    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        check({name, ".seconds"}, bus_if.seconds, m_seconds());
        check({name, ".busy"}, {8'h00, bus_if.busy},
              {8'h00, (m_mode == M_RUN) || (m_mode == M_PAUSED)});
        check({name, ".done"}, {8'h00, bus_if.done}, {8'h00, m_mode == M_EXPIRED});
    endtask

    task automatic drive(input logic st, input logic [7:0] ld, input logic pa, input logic ca);
        bus_if.start    = st;
        bus_if.load_bcd = ld;
        bus_if.pause    = pa;
        bus_if.cancel   = ca;
    endtask

    // Advance one clock, update the model with the sampled inputs, settle.
    task automatic step();
        @(posedge clk_out);
        model_step(bus_if.start, bus_if.load_bcd, bus_if.pause, bus_if.cancel);
        #1;
    endtask

    // ---------------- vector table ------------------------------------------
    typedef struct {
        logic       st;
        logic [7:0] ld;
        logic       pa;
        logic       ca;
        logic [8:0] e_sec;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic [7:0] ld, input logic pa, input logic ca,
                       input logic [8:0] s, input logic b, input logic d);
        vec_t v;
        v.st = st; v.ld = ld; v.pa = pa; v.ca = ca;
        v.e_sec = s; v.e_busy = b; v.e_done = d;
        vecs.push_back(v);
    endtask

    task automatic add_hold(input int n, input logic [8:0] s);
        for (int i = 0; i < n; i++) add(1'b0, 8'h00, 1'b0, 1'b0, s, 1'b1, 1'b0);
    endtask

    initial begin
        logic pa_r;

        // basic count 03 -> 00
        add(1'b1, 8'h03, 1'b0, 1'b0, 9'h103, 1'b1, 1'b0);
        add_hold(3, 9'h103);
        add_hold(4, 9'h102);
        add_hold(4, 9'h101);
        add(1'b0, 8'h00, 1'b0, 1'b0, 9'h100, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        // BCD borrow 10 -> 09
        add(1'b1, 8'h10, 1'b0, 1'b0, 9'h110, 1'b1, 1'b0);
        add_hold(3, 9'h110);
        add_hold(1, 9'h109);
        // sanitising AF -> 99 -> 98 (also a restart, no done)
        add(1'b1, 8'hAF, 1'b0, 1'b0, 9'h199, 1'b1, 1'b0);
        add_hold(3, 9'h199);
        add_hold(1, 9'h198);
        add(1'b0, 8'h00, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
        // zero load expires immediately
        add(1'b1, 8'h00, 1'b0, 1'b0, 9'h100, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        // start and cancel together: cancel wins
        add(1'b1, 8'h55, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0);

        // ---------------- reset -----------------------------------------------
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        #12;
        check("reset.seconds", bus_if.seconds, 9'h000);
        check("reset.busy", {8'h00, bus_if.busy}, 9'h000);
        check("reset.done", {8'h00, bus_if.done}, 9'h000);
        reset = 1'b1;
        step();

        // ---------------- table -----------------------------------------------
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].ld, vecs[i].pa, vecs[i].ca);
            step();
            check($sformatf("vec%0d.seconds", i), bus_if.seconds, vecs[i].e_sec);
            check($sformatf("vec%0d.busy", i), {8'h00, bus_if.busy}, {8'h00, vecs[i].e_busy});
            check($sformatf("vec%0d.done", i), {8'h00, bus_if.done}, {8'h00, vecs[i].e_done});
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // ---------------- pause holds the prescaler ---------------------------
        drive(1'b1, 8'h05, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("pause.seconds", bus_if.seconds, 9'h105);
            check("pause.busy", {8'h00, bus_if.busy}, 9'h001);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("resume1.seconds", bus_if.seconds, 9'h105);
        step();
        check("resume2.seconds", bus_if.seconds, 9'h104);
        check_model("resume2");

        // ---------------- cancel at 07 ----------------------------------------
        drive(1'b1, 8'h07, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("c107.seconds", bus_if.seconds, 9'h107);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        check("cancel.seconds", bus_if.seconds, 9'h000);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("cancel.done", {8'h00, bus_if.done}, 9'h000);
        end

        // ---------------- restart at 07 with 42 -------------------------------
        drive(1'b1, 8'h07, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        drive(1'b1, 8'h42, 1'b0, 1'b0);
        step();
        check("restart.seconds", bus_if.seconds, 9'h142);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("restart.hold", bus_if.seconds, 9'h142);
            check("restart.done", {8'h00, bus_if.done}, 9'h000);
        end
        step();
        check("restart.tick", bus_if.seconds, 9'h141);

        // ---------------- asynchronous reset mid-run --------------------------
        drive(1'b1, 8'h56, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("pre_rst.seconds", bus_if.seconds, 9'h156);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("arst.seconds", bus_if.seconds, 9'h000);
        check("arst.busy", {8'h00, bus_if.busy}, 9'h000);
        check("arst.done", {8'h00, bus_if.done}, 9'h000);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst.seconds", bus_if.seconds, 9'h000);
            check_model("post_rst");
        end

        // ---------------- randomized against the model ------------------------
        pa_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic       st;
            logic       ca;
            logic [7:0] ld;
            st = ($urandom_range(0, 15) == 0);
            ca = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) pa_r = ~pa_r;
            if ($urandom_range(0, 1) == 0) ld = 8'($urandom_range(0, 3));
            else                           ld = 8'($urandom_range(0, 255));
            drive(st, ld, pa_r, ca);
            step();
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Upstream stage of the seven-segment display driver. Produces the 9-bit `seconds` bus the display consumes: bit 8 is the "countdown active" flag, bits 7:0 are two BCD digits (tens, ones) in the range 00–99.
- Counts down once per second from a loaded BCD value.
- Supports pause, cancel and restart.
- Emits a one-cycle `done` pulse at expiry so the menu FSM can time out an operation.

Parameters:
- TICKS_PER_SEC, 20000: number of clk_out cycles per one-second decrement. Legal range is 2 to 2^20.
- PRESC_W, 20: prescaler counter width. Must satisfy 2^PRESC_W >= TICKS_PER_SEC.

Ports:
- clk_out  input  1  block clock (the divided system clock).
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; loads `load_bcd` and begins or restarts the countdown.
- load_bcd  input  8  start value in BCD; [7:4] is tens, [3:0] is ones.
- pause  input  1  level; while high, counting is frozen.
- cancel  input  1  single-cycle pulse; aborts the countdown without asserting `done`.
- seconds  output  9  {active, tens_bcd, ones_bcd}; connects directly to the display's `seconds` input.
- busy  output  1  high in the RUN or PAUSE state.
- done  output  1  one-cycle pulse when the count reaches 00.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, seconds=9'h000, busy=0, done=0, prescaler=0. All outputs are registered.
- States: IDLE, RUN, PAUSE, EXPIRE.
- Input priority in any cycle: cancel > start > pause.
- cancel, from any state: next state IDLE, seconds=9'h000, prescaler=0, done stays 0.
- Input sanitising: each `load_bcd` nibble greater than 9 is saturated to 9 at load. Example: 8'hAF loads as 99.
- start in IDLE, RUN, PAUSE or EXPIRE:
  - Sanitised value is non-zero: next state RUN, seconds={1'b1, value}, prescaler=0.
  - Sanitised value is 00: next state EXPIRE, seconds=9'h100.
  - A start in RUN or PAUSE is a restart with the new value. No `done` is asserted for the aborted count.
- RUN:
  - Prescaler increments every cycle.
  - When prescaler = TICKS_PER_SEC-1, the cycle is a tick: prescaler wraps to 0 and the BCD value decrements.
  - First decrement occurs exactly TICKS_PER_SEC cycles after the start cycle.
- BCD decrement rule:
  - ones≠0: ones−1.
  - ones=0: ones=9 and tens−1.
  - Binary arithmetic must never appear on the bus: 10 → 09, never 0F.
- Expiry: a tick that takes the value from 01 to 00 moves the state to EXPIRE with seconds=9'h100.
- EXPIRE (exactly one cycle): done=1. Next state IDLE with seconds=9'h000 and done=0.
- pause:
  - While in RUN with pause=1, the next state is PAUSE. The prescaler holds its value (it is not cleared); the value and the active bit hold.
  - While in PAUSE with pause=0, the next state is RUN and the prescaler resumes from the held count.
  - pause has no effect in IDLE or EXPIRE.
- pause together with a tick, same cycle: the tick takes effect (decrement, prescaler wraps), then the state becomes PAUSE.
- pause while the value is 01 and the tick arrives: the block expires normally. Pause does not mask expiry.
- busy = (state==RUN) || (state==PAUSE). It is 0 in EXPIRE.
- done is asserted only from EXPIRE, never from cancel or restart.
- Reset asserted mid-count: all outputs clear immediately (asynchronous). After release, the block sits in IDLE until the next start.
- No latches; all next-state logic is fully assigned.

Test Plan (TICKS_PER_SEC=4):
1. Basic count: reset, then start with load_bcd=8'h03.
   - seconds reads 103 → 102 → 101 → 100, each transition 4 cycles apart.
   - done=1 for exactly one cycle while seconds=100.
   - Next cycle: seconds=000, busy=0.
2. BCD borrow and sanitising:
   - load 8'h10: after one tick, seconds=109 (not 10F).
   - load 8'hAF: seconds=199; after one tick, 198.
3. Pause:
   - Start with 8'h05, raise pause after 2 cycles, hold it for 20 cycles: seconds stays 105 and busy=1.
   - Release pause: the next tick occurs 2 cycles later (resumed prescaler), giving 104.
4. Cancel and restart:
   - During a count at 107, pulse cancel: the next cycle shows seconds=000, done never asserts.
   - During a count at 107, pulse start with 8'h42: seconds=142, prescaler restarts at 0, no done pulse.
5. Zero load and simultaneous events:
   - start with 8'h00: one cycle of seconds=100 with done=1, then 000.
   - start and cancel asserted together: cancel wins, seconds=000.
6. Asynchronous reset mid-run:
   - Drop reset between clock edges while at 156: seconds=000, busy=0 and done=0 before the next edge.
   - Stays IDLE after reset release.
